// File: rtl/player_death_controller.sv
// Player death sequencer: turns raw collision hits into one player_died pulse per death,
// then runs the death freeze, respawn, blinking invulnerability and sticky game over.
module player_death_controller #(
    parameter int DEATH_FRAMES  = 90,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_BIT     = 3,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic hit_monster,
    input  logic hit_bag,
    input  logic no_lives,
    output logic player_died,
    output logic respawn,
    output logic freeze_player,
    output logic player_visible,
    output logic game_over
);

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DYING     = 2'd1,
        INVULN    = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEATH_LAST  = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0] INVULN_LAST = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             hit;
    logic             died_nxt, respawn_nxt, freeze_nxt, visible_nxt, over_nxt;

    assign hit = hit_monster | hit_bag;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= ALIVE;
            cnt            <= '0;
            player_died    <= 1'b0;
            respawn        <= 1'b0;
            freeze_player  <= 1'b0;
            player_visible <= 1'b1;
            game_over      <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            player_died    <= died_nxt;
            respawn        <= respawn_nxt;
            freeze_player  <= freeze_nxt;
            player_visible <= visible_nxt;
            game_over      <= over_nxt;
        end
    end

    // Next state and counter; SOFs are only counted while a timed phase is running,
    // so an SOF coinciding with the fatal hit never counts toward the freeze.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        died_nxt    = 1'b0;
        respawn_nxt = 1'b0;
        case (state)
            ALIVE: begin
                if (hit) begin
                    state_nxt = DYING;
                    cnt_nxt   = '0;
                    died_nxt  = 1'b1;
                end
            end
            DYING: begin
                if (startOfFrame) begin
                    if (cnt == DEATH_LAST) begin
                        cnt_nxt = '0;
                        if (no_lives) begin
                            state_nxt = GAME_OVER;
                        end else begin
                            state_nxt   = INVULN;
                            respawn_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            INVULN: begin
                if (startOfFrame) begin
                    if (cnt == INVULN_LAST) begin
                        state_nxt = ALIVE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            GAME_OVER: begin
                state_nxt = GAME_OVER;
            end
            default: begin
                state_nxt = ALIVE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Level outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        freeze_nxt  = 1'b0;
        visible_nxt = 1'b1;
        over_nxt    = 1'b0;
        case (state_nxt)
            DYING:     freeze_nxt  = 1'b1;
            INVULN:    visible_nxt = ~cnt_nxt[BLINK_BIT];
            GAME_OVER: begin
                freeze_nxt  = 1'b1;
                visible_nxt = 1'b0;
                over_nxt    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_player_death_controller.sv
// Bench for player_death_controller: phase/frame model compared every cycle, plus
// directed scenarios with literal expectations on pulses, timing and frame counts.
module tb_player_death_controller;

    localparam int DF    = 90;
    localparam int IVF   = 120;
    localparam int FRAME = 16;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic sof = 1'b0;
    logic hm = 1'b0;
    logic hb = 1'b0;
    logic nl = 1'b0;
    logic player_died, respawn, freeze_player, player_visible, game_over;

    player_death_controller #(
        .DEATH_FRAMES(DF), .INVULN_FRAMES(IVF), .BLINK_BIT(3), .CNT_W(8)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .hit_monster(hm), .hit_bag(hb), .no_lives(nl),
        .player_died(player_died), .respawn(respawn), .freeze_player(freeze_player),
        .player_visible(player_visible), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Free-running frame pulse, one cycle in every FRAME.
    bit sof_en = 1'b0;
    int sof_ph = 0;
    always @(posedge clk) begin
        #3;
        if (sof_en) begin
            sof    = (sof_ph == 0);
            sof_ph = (sof_ph + 1) % FRAME;
        end else begin
            sof    = 1'b0;
            sof_ph = 0;
        end
    end

    int sof_total = 0;
    always @(posedge clk) if (resetN && sof) sof_total++;

    // Model: phase 0 alive, 1 dying, 2 invulnerable, 3 game over; fr = frames seen in phase.
    int   ph, fr;
    logic e_died, e_resp, e_frz, e_vis, e_go;
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ph = 0; fr = 0;
            e_died = 0; e_resp = 0; e_frz = 0; e_vis = 1; e_go = 0;
        end else begin
            e_died = 0;
            e_resp = 0;
            case (ph)
                0: if (hm || hb) begin ph = 1; fr = 0; e_died = 1; end
                1: if (sof) begin
                    fr++;
                    if (fr == DF) begin
                        fr = 0;
                        if (nl) ph = 3;
                        else begin ph = 2; e_resp = 1; end
                    end
                end
                2: if (sof) begin
                    fr++;
                    if (fr == IVF) begin ph = 0; fr = 0; end
                end
                default: ;
            endcase
            e_frz = (ph == 1) || (ph == 3);
            e_go  = (ph == 3);
            if (ph == 3)      e_vis = 0;
            else if (ph == 2) e_vis = ((fr / 8) % 2) == 0;
            else              e_vis = 1;
        end
    end

    int died_cnt = 0, resp_cnt = 0, died_base = 0, resp_gap = 0;
    always @(negedge clk) begin
        chk("player_died", player_died, e_died);
        chk("respawn", respawn, e_resp);
        chk("freeze_player", freeze_player, e_frz);
        chk("player_visible", player_visible, e_vis);
        chk("game_over", game_over, e_go);
        if (player_died === 1'b1) begin died_cnt++; died_base = sof_total; end
        if (respawn === 1'b1) begin resp_cnt++; resp_gap = sof_total - died_base; end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #4;
    endtask

    task automatic wait_sofs(input int n, input string name);
        int target;
        int lim;
        target = sof_total + n;
        lim    = (n + 2) * FRAME;
        while (sof_total < target && lim > 0) begin cyc(1); lim--; end
        if (sof_total < target) timeout_fail(name);
    endtask

    task automatic wait_resp(input string name);
        int lim;
        lim = (DF + 2) * FRAME;
        while (respawn !== 1'b1 && lim > 0) begin cyc(1); lim--; end
        if (respawn !== 1'b1) timeout_fail(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: reset and idle
        resetN = 1'b0;
        cyc(3);
        chk("rst died", player_died, 0);
        chk("rst respawn", respawn, 0);
        chk("rst freeze", freeze_player, 0);
        chk("rst visible", player_visible, 1);
        chk("rst game_over", game_over, 0);
        resetN = 1'b1;
        sof_en = 1'b1;
        wait_sofs(10, "t1 idle frames");
        chk("t1 no died", died_cnt, 0);
        chk("t1 no respawn", resp_cnt, 0);
        chk("t1 visible", player_visible, 1);

        // 2: long monster hit, one pulse, respawn after 90 frames
        cyc(5);
        hm = 1'b1;
        cyc(1);
        chk("t2 died pulse", player_died, 1);
        cyc(1);
        chk("t2 died one cycle", player_died, 0);
        chk("t2 frozen", freeze_player, 1);
        cyc(198);
        hm = 1'b0;
        wait_resp("t2 respawn");
        cyc(1);
        chk("t2 respawn after 90 sofs", resp_gap, DF);
        chk("t2 died count", died_cnt, 1);
        chk("t2 respawn count", resp_cnt, 1);
        chk("t2 unfrozen", freeze_player, 0);

        // 3: bag hits every invulnerable frame, blink, then a real death
        for (int i = 1; i <= IVF; i++) begin
            cyc(3);
            hb = 1'b1;
            cyc(1);
            hb = 1'b0;
            if (i == 4)  chk("t3 visible frame 4", player_visible, 1);
            if (i == 12) chk("t3 hidden frame 12", player_visible, 0);
            if (i == 20) chk("t3 visible frame 20", player_visible, 1);
            if (i == IVF) hb = 1'b1;
            wait_sofs(1, "t3 frame");
            hb = 1'b0;
        end
        cyc(1);
        chk("t3 no death while immune", died_cnt, 1);
        chk("t3 visible after immunity", player_visible, 1);
        cyc(3);
        hb = 1'b1;
        cyc(1);
        hb = 1'b0;
        chk("t3 died frame 121", player_died, 1);
        cyc(1);
        chk("t3 died count", died_cnt, 2);

        // 4: out of lives at the end of the freeze
        nl = 1'b1;
        wait_sofs(DF, "t4 freeze frames");
        chk("t4 game_over", game_over, 1);
        chk("t4 hidden", player_visible, 0);
        chk("t4 no respawn", respawn, 0);
        for (int i = 0; i < 50; i++) begin
            cyc(3);
            hm = 1'b1;
            cyc(2);
            hm = 1'b0;
            wait_sofs(1, "t4 over frame");
        end
        chk("t4 no died in game over", died_cnt, 2);
        chk("t4 respawn count", resp_cnt, 1);
        chk("t4 still over", game_over, 1);
        resetN = 1'b0;
        #2;
        chk("t4 reset clears over", game_over, 0);
        chk("t4 reset visible", player_visible, 1);
        chk("t4 reset unfrozen", freeze_player, 0);
        cyc(2);
        resetN = 1'b1;
        nl = 1'b0;

        // 5: hit on the same cycle as SOF
        begin
            int lim;
            lim = 2 * FRAME;
            cyc(1);
            while (sof !== 1'b1 && lim > 0) begin cyc(1); lim--; end
            if (sof !== 1'b1) timeout_fail("t5 sof align");
        end
        hm = 1'b1;
        cyc(1);
        hm = 1'b0;
        chk("t5 died pulse", player_died, 1);
        wait_resp("t5 respawn");
        cyc(1);
        chk("t5 respawn after 90 further sofs", resp_gap, DF);
        chk("t5 respawn count", resp_cnt, 2);

        // 6: reset five frames into invulnerability
        wait_sofs(5, "t6 invuln frames");
        cyc(3);
        resetN = 1'b0;
        #2;
        chk("t6 reset visible", player_visible, 1);
        chk("t6 reset unfrozen", freeze_player, 0);
        chk("t6 reset no respawn", respawn, 0);
        cyc(2);
        resetN = 1'b1;
        wait_sofs(20, "t6 idle");
        chk("t6 no extra respawn", resp_cnt, 2);
        cyc(3);
        hm = 1'b1;
        cyc(1);
        hm = 1'b0;
        chk("t6 alive after reset", player_died, 1);
        cyc(3);
        chk("t6 died count", died_cnt, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
